// File: rtl/idp_pkg.sv
// idp_pkg: shared definitions for the two-stage integer datapath.
//   - opcode encodings OP_ADD..OP_SBB (11..15 are reserved)
//   - bit positions of N/Z/C/V inside the packed flag vector
//   - alu_res_t and the combinational ALU function idp_alu
// The ALU works on a MAX_DW-bit container; the caller passes the real
// width so one function serves every DW up to MAX_DW.
package idp_pkg;

    localparam int MAX_DW = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_ADC  = 4'd9;
    localparam logic [3:0] OP_SBB  = 4'd10;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef struct packed {
        logic [MAX_DW-1:0] result;
        logic              n;
        logic              z;
        logic              c;
        logic              v;
    } alu_res_t;

    localparam logic [MAX_DW:0] ONE = {{MAX_DW{1'b0}}, 1'b1};

    // Bit idx of x, with idx only known as a run-time value to the function.
    function automatic logic bit_at(input logic [MAX_DW:0] x, input int unsigned idx);
        logic [MAX_DW:0] t;
        t = x >> idx;
        return t[0];
    endfunction

    function automatic alu_res_t idp_alu(
        input logic [3:0]        op,
        input logic [MAX_DW-1:0] a,
        input logic [MAX_DW-1:0] b,
        input logic              cin,
        input int unsigned       dw
    );
        logic [MAX_DW:0] mask, wa, wb, nb, ci, sum;
        logic            sa, sb, sr, is_add, is_sub;
        alu_res_t        r;
        mask   = (ONE << dw) - ONE;
        wa     = {1'b0, a} & mask;
        wb     = {1'b0, b} & mask;
        nb     = ~wb & mask;
        ci     = {{MAX_DW{1'b0}}, cin};
        sum    = '0;
        r      = '0;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (op)
            OP_ADD:  begin sum = wa + wb;       is_add = 1'b1; end
            OP_ADC:  begin sum = wa + wb + ci;  is_add = 1'b1; end
            // Subtract as A + ~B + carry-in: bit dw of the sum is then
            // the no-borrow flag directly.
            OP_SUB:  begin sum = wa + nb + ONE; is_sub = 1'b1; end
            OP_SBB:  begin sum = wa + nb + ci;  is_sub = 1'b1; end
            OP_AND:  sum = wa & wb;
            OP_OR:   sum = wa | wb;
            OP_XOR:  sum = wa ^ wb;
            OP_NOT:  sum = ~wa & mask;
            OP_SHL:  begin sum = wa << 1; r.c = bit_at(wa, dw - 1); end
            OP_SHR:  begin sum = wa >> 1; r.c = wa[0]; end
            OP_PASS: sum = wb;
            default: sum = '0;
        endcase
        if (is_add || is_sub) r.c = bit_at(sum, dw);
        r.result = sum[MAX_DW-1:0] & mask[MAX_DW-1:0];
        sa  = bit_at(wa, dw - 1);
        sb  = bit_at(wb, dw - 1);
        sr  = bit_at({1'b0, r.result}, dw - 1);
        r.n = sr;
        r.z = (r.result == '0);
        if (is_add)      r.v = (sa == sb) && (sr != sa);
        else if (is_sub) r.v = (sa != sb) && (sr != sa);
        return r;
    endfunction

endpackage

// File: rtl/idp_regfile.sv
// idp_regfile: NREG x DW general register file.
//   clk        clock
//   rst_ni     asynchronous active-low clear of every entry
//   we_i       write enable, waddr_i/wdata_i written on the rising edge
//   raddr_a_i  -> rdata_a_o  asynchronous read port A
//   raddr_b_i  -> rdata_b_o  asynchronous read port B
module idp_regfile
    import idp_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem [NREG];

    // One register per entry so the whole file clears asynchronously.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        logic [DW-1:0] entry_q;
        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_q <= '0;
            end else if (we_i && (waddr_i == AW'(gi))) begin
                entry_q <= wdata_i;
            end
        end
        assign mem[gi] = entry_q;
    end

    assign rdata_a_o = mem[raddr_a_i];
    assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/idp_pipe.sv
// idp_pipe: two-stage integer datapath.
//   S1 captures a decoded instruction with its operands (register read,
//   immediate select, forwarding from the instruction currently in S1).
//   S2 is the ALU output: result/res_rd/flags registers plus writeback.
// Ports:
//   clk, rst (async active-low)
//   in_valid, stall, in_ready      accept handshake; stall freezes everything
//   opcode, we, rd, ra, rb,
//   sel_imm, imm                   decoded instruction
//   fir                            registered S1 operand A
//   result, res_rd, out_valid      registered S2 result
//   N, Z, C, V                     registered flags
module idp_pipe
    import idp_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          stall,
    output logic          in_ready,
    input  logic [3:0]    opcode,
    input  logic          we,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic          sel_imm,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] fir,
    output logic [DW-1:0] result,
    output logic [AW-1:0] res_rd,
    output logic          out_valid,
    output logic          N,
    output logic          Z,
    output logic          C,
    output logic          V
);

    logic          s1_valid_q, s1_we_q;
    logic [3:0]    s1_op_q;
    logic [AW-1:0] s1_rd_q;
    logic [DW-1:0] s1_a_q, s1_b_q;
    logic [DW-1:0] op_a_d, op_b_d, rf_a, rf_b;
    logic [DW-1:0] result_q;
    logic [AW-1:0] res_rd_q;
    logic          out_valid_q;
    logic [3:0]    flags_q, flags_d;
    alu_res_t      alu;
    logic [DW-1:0] alu_result;
    logic          op_ok, s1_writes;
    logic          unused_alu_bits;

    // Carry-in is the registered C: the instruction ahead of an ADC/SBB
    // has already updated C on the edge that captured the ADC/SBB, so the
    // registered value equals the forwarded C_next of that instruction.
    assign alu             = idp_alu(s1_op_q, MAX_DW'(s1_a_q), MAX_DW'(s1_b_q),
                                     flags_q[FLAG_C], DW);
    assign alu_result      = alu.result[DW-1:0];
    assign unused_alu_bits = ^alu.result;

    assign op_ok     = (s1_op_q <= OP_SBB);
    assign s1_writes = s1_valid_q && s1_we_q && op_ok;

    idp_regfile #(.DW(DW), .NREG(NREG)) u_rf (
        .clk       (clk),
        .rst_ni    (rst),
        .we_i      (s1_writes && !stall),
        .waddr_i   (s1_rd_q),
        .wdata_i   (alu_result),
        .raddr_a_i (ra),
        .rdata_a_o (rf_a),
        .raddr_b_i (rb),
        .rdata_b_o (rf_b)
    );

    // Forward the not-yet-written S1 result; reserved opcodes never write
    // back, so they are not forwarded either.
    always_comb begin
        op_a_d = rf_a;
        op_b_d = rf_b;
        if (s1_writes && (s1_rd_q == ra)) op_a_d = alu_result;
        if (s1_writes && (s1_rd_q == rb)) op_b_d = alu_result;
        if (sel_imm)                      op_b_d = imm;
    end

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = alu.n;
        flags_d[FLAG_Z] = alu.z;
        flags_d[FLAG_C] = alu.c;
        flags_d[FLAG_V] = alu.v;
    end

    // S1: a bubble only clears the valid bit, the payload is left as is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_we_q <= we;
                s1_op_q <= opcode;
                s1_rd_q <= rd;
                s1_a_q  <= op_a_d;
                s1_b_q  <= op_b_d;
            end
        end
    end

    // S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q    <= '0;
            res_rd_q    <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
        end else if (!stall) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= alu_result;
                res_rd_q <= s1_rd_q;
                if (op_ok) flags_q <= flags_d;
            end
        end
    end

    assign in_ready  = !stall;
    assign fir       = s1_a_q;
    assign result    = result_q;
    assign res_rd    = res_rd_q;
    assign out_valid = out_valid_q;
    assign N         = flags_q[FLAG_N];
    assign Z         = flags_q[FLAG_Z];
    assign C         = flags_q[FLAG_C];
    assign V         = flags_q[FLAG_V];

endmodule

// File: tb/tb_idp_pipe.sv
module tb_idp_pipe;
    import idp_pkg::*;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    localparam logic [DW-1:0] ALL1   = '1;
    localparam logic [DW-1:0] MAXPOS = ALL1 >> 1;
    localparam logic [DW-1:0] MINNEG = ~MAXPOS;

    typedef struct packed {
        logic [DW-1:0] res;
        logic [AW-1:0] rd;
        logic [3:0]    f;   // {N,Z,C,V}
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, stall, in_ready, we, sel_imm, out_valid;
    logic [3:0]    opcode;
    logic [AW-1:0] rd, ra, rb, res_rd;
    logic [DW-1:0] imm, fir, result;
    logic          fn, fz, fc, fv;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    logic adv_q  = 1'b0;

    idp_pipe #(.DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .in_ready(in_ready),
        .opcode(opcode), .we(we), .rd(rd), .ra(ra), .rb(rb), .sel_imm(sel_imm), .imm(imm),
        .fir(fir), .result(result), .res_rd(res_rd), .out_valid(out_valid),
        .N(fn), .Z(fz), .C(fc), .V(fv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Did the last rising edge advance the pipeline?
    always @(posedge clk) adv_q <= rst && !stall;

    // Monitor: one new output per advancing edge with out_valid set.
    always @(negedge clk) begin
        if (adv_q && out_valid) begin
            exp_t got, e;
            got = {result, res_rd, {fn, fz, fc, fv}};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got res=%h rd=%0d nzcv=%b, expected nothing",
                         result, res_rd, got.f);
            end else begin
                e = q.pop_front();
                txn++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL txn%0d: got res=%h rd=%0d nzcv=%b, expected res=%h rd=%0d nzcv=%b",
                             txn, got.res, got.rd, got.f, e.res, e.rd, e.f);
                end else begin
                    $display("txn%0d ok: res=%h rd=%0d nzcv=%b", txn, got.res, got.rd, got.f);
                end
            end
        end
    end

    task automatic set_in(input logic [3:0] op, input logic w, input int d, input int a,
                          input int b, input logic si, input logic [DW-1:0] im);
        in_valid = 1'b1;
        opcode   = op;
        we       = w;
        rd       = AW'(d);
        ra       = AW'(a);
        rb       = AW'(b);
        sel_imm  = si;
        imm      = im;
    endtask

    task automatic issue(input logic [3:0] op, input logic w, input int d, input int a,
                         input int b, input logic si, input logic [DW-1:0] im,
                         input logic [DW-1:0] er, input logic [3:0] f);
        exp_t e;
        set_in(op, w, d, a, b, si, im);
        e.res = er;
        e.rd  = AW'(d);
        e.f   = f;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0;
        set_in(OP_ADD, 1'b0, 0, 0, 0, 1'b0, '0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_res_rd", 64'(res_rd), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_flags", 64'({fn, fz, fc, fv}), 64'(0));
        chk("rst_fir", 64'(fir), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b1;

        //    op       we   rd ra rb imm?  imm          expected      NZCV
        issue(OP_ADD,  1'b1, 1, 0, 0, 1'b1, DW'(5),      DW'(5),       4'b0000);
        issue(OP_ADD,  1'b1, 1, 0, 0, 1'b1, MAXPOS,      MAXPOS,       4'b0000);
        issue(OP_ADD,  1'b1, 2, 1, 1, 1'b0, '0,          ALL1 - 1'b1,  4'b1001);
        issue(OP_ADD,  1'b1, 3, 2, 0, 1'b1, DW'(1),      ALL1,         4'b1000);
        issue(OP_ADD,  1'b1, 4, 3, 0, 1'b1, DW'(1),      '0,           4'b0110);
        issue(OP_ADC,  1'b1, 5, 0, 0, 1'b0, '0,          DW'(1),       4'b0000);
        issue(OP_ADD,  1'b1, 6, 0, 0, 1'b1, DW'(3),      DW'(3),       4'b0000);
        issue(OP_SUB,  1'b1, 7, 6, 0, 1'b1, DW'(5),      ALL1 - 1'b1,  4'b1000);
        issue(OP_SBB,  1'b1, 7, 6, 0, 1'b1, DW'(1),      DW'(1),       4'b0010);
        issue(OP_SHR,  1'b1, 2, 5, 0, 1'b1, '0,          '0,           4'b0110);
        issue(OP_SHL,  1'b1, 3, 1, 0, 1'b1, '0,          ALL1 - 1'b1,  4'b1000);
        issue(OP_XOR,  1'b1, 4, 1, 0, 1'b1, DW'('hFF),   MAXPOS ^ DW'('hFF), 4'b0000);
        issue(OP_NOT,  1'b1, 4, 0, 0, 1'b1, '0,          ALL1,         4'b1000);
        issue(4'd12,   1'b1, 4, 1, 1, 1'b0, '0,          '0,           4'b1000);
        bubble();
        issue(OP_PASS, 1'b1, 6, 0, 4, 1'b0, '0,          ALL1,         4'b1000);
        issue(OP_AND,  1'b1, 6, 6, 0, 1'b1, DW'('h0F0F), DW'('h0F0F),  4'b0000);
        issue(OP_OR,   1'b1, 2, 2, 0, 1'b1, MINNEG,      MINNEG,       4'b1000);
        issue(OP_ADD,  1'b1, 1, 1, 0, 1'b1, DW'(1),      MINNEG,       4'b1001);
        issue(OP_SUB,  1'b1, 5, 2, 0, 1'b1, DW'(1),      MAXPOS,       4'b0011);
        issue(OP_ADD,  1'b1, 0, 0, 0, 1'b1, DW'(9),      DW'(9),       4'b0000);
        issue(OP_PASS, 1'b0, 0, 0, 0, 1'b0, '0,          DW'(9),       4'b0000);

        // Stall with B sitting in S1 and A's result on the outputs.
        issue(OP_PASS, 1'b1, 7, 0, 0, 1'b1, DW'('h55),   DW'('h55),    4'b0000);
        issue(OP_ADD,  1'b1, 6, 7, 0, 1'b1, DW'(1),      DW'('h56),    4'b0000);
        stall = 1'b1;
        set_in(OP_ADD, 1'b1, 7, 0, 0, 1'b1, DW'('h1234));
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_result", 64'(result), 64'('h55));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_fir", 64'(fir), 64'('h55));
            chk("stall_res_rd", 64'(res_rd), 64'(7));
        end
        stall = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("unstall_out_valid", 64'(out_valid), 64'(1));
        chk("unstall_result", 64'(result), 64'('h56));
        issue(OP_PASS, 1'b0, 0, 0, 7, 1'b0, '0,          DW'('h55),    4'b0000);
        issue(OP_NOT,  1'b0, 0, 0, 0, 1'b1, '0,          ALL1 ^ DW'(9), 4'b1000);
        bubble();

        // Reset while S1 holds a valid write to r3: it must be lost.
        set_in(OP_ADD, 1'b1, 3, 0, 0, 1'b1, DW'('h33));
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_flags", 64'({fn, fz, fc, fv}), 64'(0));
        chk("midrst_result", 64'(result), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst_out_valid", 64'(out_valid), 64'(0));
        issue(OP_PASS, 1'b0, 0, 0, 3, 1'b0, '0,          '0,           4'b0100);
        issue(OP_PASS, 1'b0, 0, 0, 0, 1'b0, '0,          '0,           4'b0100);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idp_pipe.md
Name: idp_pipe

Overview:
- Parametrised two-stage successor to the single-cycle integer datapath.
- Stage S1 captures the decoded instruction and its operands: register-file read, immediate select, forwarding.
- Stage S2 executes on the ALU, writes back to the register file and updates the registered flags.
- Adds a valid/stall handshake, result forwarding, V flag and add-with-carry; sits between the instruction decoder and the core control FSM.

Parameters:
DW, 16, datapath width in bits (>=4)
NREG, 8, number of general registers (power of 2, >=2)
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  instruction present on decode inputs
stall  in  1  freeze whole pipeline
in_ready  out  1  = !stall (combinational)
opcode  in  4  ALU operation
we  in  1  instruction writes rd
rd  in  AW  destination register
ra  in  AW  operand A register
rb  in  AW  operand B register
sel_imm  in  1  1: operand B = imm, 0: operand B = reg[rb]
imm  in  DW  immediate operand
fir  out  DW  S1 operand A, registered (debug/address use)
result  out  DW  registered S2 result
res_rd  out  AW  destination of result
out_valid  out  1  result/flags updated by a valid instruction
N, Z, C, V  out  1 each  registered flags

Behaviour:
- Reset (rst=0, async): all registers, fir, result, res_rd and the flags go to 0; out_valid and the S1 valid bit go to 0.
- Accept: an edge with in_valid=1 and stall=0 loads S1 (op, we, rd, opA, opB, valid=1). in_valid=0 and stall=0 loads a bubble (valid=0).
- Latency: an instruction accepted at edge k has result, res_rd, N/Z/C/V and out_valid=1 visible after edge k+1.
  - Register write happens at edge k+1.
  - The register value is readable by instructions accepted at edge k+1 onward.
- Forwarding: at capture, if S1 is valid, S1.we=1 and S1.rd equals ra (or rb), the operand takes the combinational S2 ALU result instead of the register file. Immediates are never forwarded.
- Carry forwarding: ADC/SBB use C_next of the S1 instruction if it is valid and flag-writing, else the registered C.
- stall=1:
  - no register changes (S1, register file, result, flags, out_valid all hold);
  - in_ready=0;
  - the decode inputs are ignored.
- out_valid=1 for exactly one cycle per executed valid instruction, except under stall, where it holds.
- Opcodes (DW-bit, modulo 2^DW):
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by 1
  - 7 SHR A by 1 (logical)
  - 8 PASS B
  - 9 ADC A+B+C
  - 10 SBB A-B-!C (C meaning no-borrow)
  - 11-15 reserved: result=0, no writeback, flags unchanged, out_valid still 1.
- Flags (updated only by opcodes 0-10):
  - N = result[DW-1]; Z = (result==0).
  - C: carry-out for ADD/ADC; no-borrow (A>=B unsigned, incl. carry) for SUB/SBB; shifted-out bit for SHL/SHR; 0 for logic ops and PASS.
  - V: signed overflow for ADD/ADC/SUB/SBB; 0 otherwise.
- Writeback when S1 valid, S1.we=1, opcode<=10 and stall=0. Register 0 is an ordinary register.
- Mid-operation reset clears S1; the in-flight instruction is lost with no writeback.

Decomposition:
- Package idp_pkg: opcode localparams (OP_ADD..OP_SBB), flag index constants, alu_res_t struct {result, n, z, c, v}.
- Sub-module idp_regfile(DW, NREG):
  - two asynchronous read ports, one synchronous write port;
  - async active-low clear of all entries.
- The ALU stays inline as a combinational function in idp_pkg.

Test Plan:
- Reset then ADD r1=imm 5 (ra=r0, sel_imm) -> next cycle result=5, res_rd=1, out_valid=1, Z=0, C=0.
- Back-to-back: r1=0x7FFF; ADD r2=r1+r1 in the next cycle -> forwarding gives result=0xFFFE, N=1, V=1, C=0.
- ADD 0xFFFF+1 -> result=0, Z=1, C=1; following ADC 0+0 (carry forwarded) -> result=1, C=0.
- SUB 3-5 -> 0xFFFE, N=1, C=0; SHR 0x0001 -> 0, Z=1, C=1.
- stall=1 for 3 cycles with an instruction in S1 -> result, flags, registers and out_valid frozen; in_ready=0; completes one cycle after stall drops.
- Reset asserted while S1 holds a valid write to r3 -> r3 stays 0; out_valid=0; flags 0.
- Regression run with DW=32, NREG=16: same scenarios pass, sign bit at 31.
